// File: rtl/vga_cell_addr_gen.sv
// ============================================================================
// Module  : vga_cell_addr_gen
// Brief   : Raster (x,y) to character-cell address and glyph sub-row/column
//           mapper, 1-cycle registered latency, 1x/2x scaling, wrap at DEPTH.
//           Optional vertical scroll by whole cell rows: VGA_CELL_ADDR_SCROLL_EN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_cell_addr_gen #(
  parameter int H_START  = 145,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480,
  parameter int CELL_W   = 8,
  parameter int CELL_H   = 8,
  parameter int COLS     = 80,
  parameter int DEPTH    = 4800,
  parameter int ADDR_W   = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              scale_2x,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef VGA_CELL_ADDR_SCROLL_EN
  input  logic [6:0]        scroll_rows,
`endif
  output logic [ADDR_W-1:0] addr_out,
  output logic [3:0]        sub_x,
  output logic [3:0]        sub_y,
  output logic              active_out,
  output logic              frame_start
);

  localparam int AW1 = ADDR_W + 1;

  localparam logic [9:0] X_PREP  = 10'(H_START - 1);
  localparam logic [9:0] X_FIRST = 10'(H_START);
  localparam logic [9:0] X_LAST  = 10'(H_START + H_ACTIVE - 1);
  localparam logic [9:0] X_END   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] Y_FIRST = 10'(V_START);
  localparam logic [9:0] Y_LAST  = 10'(V_START + V_ACTIVE - 1);

  localparam logic [AW1-1:0]    DEPTH_W   = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  logic              armed;
  logic              scale_r;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] cur_addr;
  logic [4:0]        px_cnt;
  logic [4:0]        ln_cnt;

  logic              at_origin;
  logic              x_act;
  logic              y_act;
  logic [4:0]        px_last;
  logic [4:0]        ln_last;
  logic [AW1-1:0]    cols_e;
  logic [AW1-1:0]    row_sum;
  logic [ADDR_W-1:0] next_row_base;
  logic [ADDR_W-1:0] next_cur_addr;
  logic [31:0]       start_sum;
  logic [ADDR_W-1:0] start_base;

  assign at_origin = (x == 10'd0) && (y == 10'd0);
  assign x_act     = (x >= X_FIRST) && (x <= X_LAST);
  assign y_act     = (y >= Y_FIRST) && (y <= Y_LAST);

  assign px_last = scale_r ? 5'(CELL_W * 2 - 1) : 5'(CELL_W - 1);
  assign ln_last = scale_r ? 5'(CELL_H * 2 - 1) : 5'(CELL_H - 1);
  assign cols_e  = scale_r ? AW1'(COLS / 2) : AW1'(COLS);

  // Both operands are already below DEPTH, so a single conditional subtract wraps.
  assign row_sum       = {1'b0, line_base} + cols_e;
  assign next_row_base = (row_sum >= DEPTH_W) ? ADDR_W'(row_sum - DEPTH_W)
                                              : ADDR_W'(row_sum);
  assign next_cur_addr = (cur_addr == ADDR_LAST) ? '0 : cur_addr + 1'b1;

  // Frame-start base uses the incoming scale since it is latched in the same cycle.
`ifdef VGA_CELL_ADDR_SCROLL_EN
  assign start_sum = 32'(base_addr)
                   + 32'(scroll_rows) * (scale_2x ? 32'(COLS / 2) : 32'(COLS));
`else
  assign start_sum = 32'(base_addr);
`endif
  assign start_base = ADDR_W'(start_sum % 32'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed       <= 1'b0;
      scale_r     <= 1'b0;
      line_base   <= '0;
      cur_addr    <= '0;
      px_cnt      <= '0;
      ln_cnt      <= '0;
      addr_out    <= '0;
      sub_x       <= '0;
      sub_y       <= '0;
      active_out  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= at_origin;

      if (at_origin) begin
        armed     <= 1'b1;
        scale_r   <= scale_2x;
        line_base <= start_base;
        ln_cnt    <= '0;
      end else begin
        if ((x == X_END) && y_act) begin
          if (ln_cnt == ln_last) begin
            ln_cnt    <= '0;
            line_base <= next_row_base;
          end else begin
            ln_cnt <= ln_cnt + 1'b1;
          end
        end

        if (x == X_PREP) begin
          px_cnt   <= '0;
          cur_addr <= line_base;
        end else if (x_act && y_act) begin
          if (px_cnt == px_last) begin
            px_cnt   <= '0;
            cur_addr <= next_cur_addr;
          end else begin
            px_cnt <= px_cnt + 1'b1;
          end
        end
      end

      // Outputs describe the pixel sampled this cycle, before counters advance.
      if (x_act && y_act) begin
        addr_out   <= cur_addr;
        sub_x      <= scale_r ? px_cnt[4:1] : px_cnt[3:0];
        sub_y      <= scale_r ? ln_cnt[4:1] : ln_cnt[3:0];
        active_out <= armed;
      end else begin
        addr_out   <= '0;
        sub_x      <= '0;
        sub_y      <= '0;
        active_out <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_cell_addr_gen.sv
// ============================================================================
// Module  : tb_vga_cell_addr_gen
// Brief   : Scoreboard bench for vga_cell_addr_gen using compressed rasters.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_cell_addr_gen;

  localparam int H_START  = 145;
  localparam int H_ACTIVE = 640;
  localparam int V_START  = 35;
  localparam int V_ACTIVE = 480;
  localparam int CELL_W   = 8;
  localparam int CELL_H   = 8;
  localparam int COLS     = 80;
  localparam int DEPTH    = 4800;
  localparam int ADDR_W   = 13;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              scale_2x;
  logic [ADDR_W-1:0] base_addr;
`ifdef VGA_CELL_ADDR_SCROLL_EN
  logic [6:0]        scroll_rows;
`endif
  logic [ADDR_W-1:0] addr_out;
  logic [3:0]        sub_x;
  logic [3:0]        sub_y;
  logic              active_out;
  logic              frame_start;

  vga_cell_addr_gen #(
    .H_START (H_START),
    .H_ACTIVE(H_ACTIVE),
    .V_START (V_START),
    .V_ACTIVE(V_ACTIVE),
    .CELL_W  (CELL_W),
    .CELL_H  (CELL_H),
    .COLS    (COLS),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .scale_2x   (scale_2x),
    .base_addr  (base_addr),
`ifdef VGA_CELL_ADDR_SCROLL_EN
    .scroll_rows(scroll_rows),
`endif
    .addr_out   (addr_out),
    .sub_x      (sub_x),
    .sub_y      (sub_y),
    .active_out (active_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // exp packs {frame_start, active_out, addr_out, sub_x, sub_y}
  typedef struct {
    logic [22:0] exp;
    bit          full;
    int          sa, ssx, ssy;
    int          px, py;
  } entry_t;

  typedef struct {
    int ph, px, py, sa, ssx, ssy;
  } spot_t;

  entry_t sb[$];
  spot_t  spots[$];

  int n_checks = 0;
  int n_fail   = 0;
  int phase    = 0;
  bit m_armed  = 1'b0;
  bit m_scale  = 1'b0;
  int m_base   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic add_spot(input int ph, input int px, input int py,
                          input int sa, input int ssx, input int ssy);
    spot_t s;
    s.ph = ph; s.px = px; s.py = py; s.sa = sa; s.ssx = ssx; s.ssy = ssy;
    spots.push_back(s);
  endtask

  // Reference mapping by division, independent of any running counters.
  task automatic step(input int xi, input int yi);
    entry_t e;
    int col, row, s, cw, ch, ce, a, sx, sy, scr;
    bit act, frm;
    x = 10'(xi);
    y = 10'(yi);
    frm = (xi == 0) && (yi == 0);
    act = (xi >= H_START) && (xi < H_START + H_ACTIVE) &&
          (yi >= V_START) && (yi < V_START + V_ACTIVE);
    e.full = 1'b1; e.sa = -1; e.ssx = -1; e.ssy = -1; e.px = xi; e.py = yi;
    if (!rst_n) begin
      e.exp   = '0;
      m_armed = 1'b0;
    end else begin
      if (act && m_armed) begin
        s   = m_scale ? 2 : 1;
        col = xi - H_START;
        row = yi - V_START;
        cw  = CELL_W * s;
        ch  = CELL_H * s;
        ce  = COLS / s;
        a   = (m_base + (row / ch) * ce + col / cw) % DEPTH;
        sx  = (col % cw) / s;
        sy  = (row % ch) / s;
        e.exp = {frm, 1'b1, 13'(a), 4'(sx), 4'(sy)};
      end else if (act) begin
        e.exp  = {frm, 22'b0};
        e.full = 1'b0;
      end else begin
        e.exp = {frm, 22'b0};
      end
      if (frm) begin
`ifdef VGA_CELL_ADDR_SCROLL_EN
        scr = int'(scroll_rows);
`else
        scr = 0;
`endif
        m_armed = 1'b1;
        m_scale = scale_2x;
        m_base  = (int'(base_addr) + scr * (scale_2x ? COLS / 2 : COLS)) % DEPTH;
      end
    end
    foreach (spots[i]) begin
      if (spots[i].ph == phase && spots[i].px == xi && spots[i].py == yi) begin
        e.sa  = spots[i].sa;
        e.ssx = spots[i].ssx;
        e.ssy = spots[i].ssy;
      end
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Only a handful of lines are swept in full; others just see the end-of-line sample.
  task automatic run_frame(input int ph);
    phase = ph;
    step(0, 0);
    step(200, 20);
    step(100, 35);
    for (int yy = V_START; yy < V_START + V_ACTIVE; yy++) begin
      if (yy == 35 || yy == 43 || yy == 51 || yy == 100 || yy == 200 || yy == 514) begin
        for (int xx = H_START - 1; xx <= H_START + H_ACTIVE; xx++) begin
          if (ph == 4 && yy == 200 && xx == 300) rst_n = 1'b0;
          if (ph == 4 && yy == 200 && xx == 310) rst_n = 1'b1;
          if (ph == 3 && yy == 100 && xx == 400) base_addr = '0;
          if (ph == 6 && yy == 100 && xx == 400) scale_2x = 1'b1;
          step(xx, yy);
        end
      end else begin
        step(H_START + H_ACTIVE, yy);
      end
    end
  endtask

  initial begin : monitor
    entry_t      e;
    logic [22:0] obs;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        obs = {frame_start, active_out, addr_out, sub_x, sub_y};
        if (e.full)
          check_eq($sformatf("out(%0d,%0d)", e.px, e.py), 32'(obs), 32'(e.exp));
        else
          check_eq($sformatf("flags(%0d,%0d)", e.px, e.py), 32'(obs[22:21]), 32'(e.exp[22:21]));
        if (e.sa >= 0)
          check_eq($sformatf("spot_addr(%0d,%0d)", e.px, e.py), 32'(addr_out), 32'(e.sa));
        if (e.ssx >= 0)
          check_eq($sformatf("spot_subx(%0d,%0d)", e.px, e.py), 32'(sub_x), 32'(e.ssx));
        if (e.ssy >= 0)
          check_eq($sformatf("spot_suby(%0d,%0d)", e.px, e.py), 32'(sub_y), 32'(e.ssy));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    x         = '0;
    y         = '0;
    scale_2x  = 1'b0;
    base_addr = '0;
`ifdef VGA_CELL_ADDR_SCROLL_EN
    scroll_rows = '0;
`endif

    add_spot(1, 145, 35, 0, 0, 0);
    add_spot(1, 152, 35, 0, 7, -1);
    add_spot(1, 153, 35, 1, 0, -1);
    add_spot(1, 784, 35, 79, -1, -1);
    add_spot(1, 145, 43, 80, -1, 0);
    add_spot(1, 784, 514, 4799, -1, -1);
    add_spot(1, 100, 35, 0, 0, 0);
    add_spot(1, 785, 35, 0, 0, 0);
    add_spot(1, 200, 20, 0, 0, 0);
    add_spot(2, 159, 35, 0, 7, -1);
    add_spot(2, 160, 35, 0, 7, -1);
    add_spot(2, 161, 35, 1, 0, -1);
    add_spot(2, 784, 35, 39, -1, -1);
    add_spot(2, 145, 51, 40, -1, 0);
    add_spot(2, 784, 514, 1199, -1, -1);
    add_spot(3, 145, 35, 4790, -1, -1);
    add_spot(3, 225, 35, 0, -1, -1);
    add_spot(3, 145, 43, 70, -1, -1);
    add_spot(3, 145, 200, 1590, -1, -1);
    add_spot(5, 145, 35, 0, 0, 0);
    add_spot(6, 784, 514, 4799, -1, -1);
    add_spot(7, 784, 35, 39, -1, -1);
    add_spot(8, 145, 35, 4720, -1, -1);
    add_spot(8, 145, 43, 0, -1, -1);
    add_spot(9, 145, 35, 3200, -1, -1);

    @(negedge clk);
    repeat (3) step(5, 5);
    rst_n = 1'b1;
    step(5, 5);

    run_frame(1);
    scale_2x = 1'b1;
    run_frame(2);
    scale_2x  = 1'b0;
    base_addr = 13'd4790;
    run_frame(3);
    base_addr = '0;
    run_frame(4);
    run_frame(5);
    run_frame(6);
    run_frame(7);
`ifdef VGA_CELL_ADDR_SCROLL_EN
    scale_2x    = 1'b0;
    scroll_rows = 7'd59;
    run_frame(8);
    scroll_rows = '0;
`endif
    scale_2x  = 1'b0;
    base_addr = 13'd8000;
    run_frame(9);

    repeat (3) @(negedge clk);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
